// File: rtl/rv32_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the RV32 decode stage.
// slave is the decode stage's view; master is the view of whatever surrounds it.
interface rv32_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [2:0]  imm_fmt;
    logic        reg_wr_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_unsigned;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  branch_op;
    logic        mdu_en;
    logic [2:0]  mdu_op;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic        csr_imm;
    logic        ecall;
    logic        mret;
    logic        ebreak;
    logic        illegal;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, rs1, rs2, rd,
               alu_op, alu_src_a, alu_src_b, imm_fmt, reg_wr_en, mem_rd, mem_wr,
               mem_unsigned, mem_size, branch, jump, jalr, branch_op, mdu_en, mdu_op,
               csr_en, csr_op, csr_imm, ecall, mret, ebreak, illegal
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, rs1, rs2, rd,
               alu_op, alu_src_a, alu_src_b, imm_fmt, reg_wr_en, mem_rd, mem_wr,
               mem_unsigned, mem_size, branch, jump, jalr, branch_op, mdu_en, mdu_op,
               csr_en, csr_op, csr_imm, ecall, mret, ebreak, illegal
    );
endinterface

// File: rtl/rv32_decode_stage.sv
// Registered RV32I(+M, +Zicsr) decode stage with a 2-entry skid (output reg + skid reg),
// flush, sticky EBREAK halt with resume, and a saturating illegal-instruction counter.
module rv32_decode_stage #(
    parameter bit EN_M           = 1'b1,
    parameter bit EN_ZICSR       = 1'b1,
    parameter bit HALT_ON_EBREAK = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_resume,
    rv32_decode_stage_if.slave bus,
    output logic               o_halted,
    output logic [CNT_W-1:0]   o_illegal_count
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3,
                           IMM_J = 3'd4, IMM_R = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic [1:0]  alu_src_a;
        logic        alu_src_b;
        logic [2:0]  imm_fmt;
        logic        reg_wr_en, mem_rd, mem_wr, mem_unsigned;
        logic [2:0]  mem_size;
        logic        branch, jump, jalr;
        logic [2:0]  branch_op;
        logic        mdu_en;
        logic [2:0]  mdu_op;
        logic        csr_en;
        logic [1:0]  csr_op;
        logic        csr_imm;
        logic        ecall, mret, ebreak, illegal;
    } bundle_t;

    bundle_t          w_dec;
    logic             w_ok;
    logic [3:0]       w_alu_f3;
    logic [6:0]       w_op, w_f7;
    logic [2:0]       w_f3;
    logic             w_in_xfer, w_out_xfer, w_out_free;
    bundle_t          r_out, r_skid;
    logic             r_out_valid, r_skid_valid, r_halted;
    logic [CNT_W-1:0] r_cnt;

    assign w_op = bus.in_instr[6:0];
    assign w_f3 = bus.in_instr[14:12];
    assign w_f7 = bus.in_instr[31:25];

    always_comb begin
        case (w_f3)
            3'b000:  w_alu_f3 = ALU_ADD;
            3'b001:  w_alu_f3 = ALU_SLL;
            3'b010:  w_alu_f3 = ALU_SLT;
            3'b011:  w_alu_f3 = ALU_SLTU;
            3'b100:  w_alu_f3 = ALU_XOR;
            3'b101:  w_alu_f3 = ALU_SRL;
            3'b110:  w_alu_f3 = ALU_OR;
            default: w_alu_f3 = ALU_AND;
        endcase
    end

    // Register fields and funct3-derived sub-ops are passed through raw; only the
    // enables and exception flags depend on legality.
    always_comb begin
        w_dec           = '0;
        w_ok            = 1'b0;
        w_dec.pc        = bus.in_pc;
        w_dec.instr     = bus.in_instr;
        w_dec.rs1       = bus.in_instr[19:15];
        w_dec.rs2       = bus.in_instr[24:20];
        w_dec.rd        = bus.in_instr[11:7];
        w_dec.mem_size  = 3'b010;
        w_dec.branch_op = w_f3;
        w_dec.mdu_op    = w_f3;
        w_dec.csr_op    = w_f3[1:0];
        w_dec.csr_imm   = w_f3[2];
        case (w_op)
            7'b0110111: begin
                w_ok = 1'b1; w_dec.imm_fmt = IMM_U; w_dec.alu_src_a = 2'b10;
                w_dec.alu_src_b = 1'b1; w_dec.reg_wr_en = 1'b1;
            end
            7'b0010111: begin
                w_ok = 1'b1; w_dec.imm_fmt = IMM_U; w_dec.alu_src_a = 2'b01;
                w_dec.alu_src_b = 1'b1; w_dec.reg_wr_en = 1'b1;
            end
            7'b1101111: begin
                w_ok = 1'b1; w_dec.imm_fmt = IMM_J; w_dec.alu_src_a = 2'b01;
                w_dec.alu_src_b = 1'b1; w_dec.jump = 1'b1; w_dec.reg_wr_en = 1'b1;
            end
            7'b1100111: begin
                w_ok = (w_f3 == 3'b000); w_dec.alu_src_b = 1'b1;
                w_dec.jump = 1'b1; w_dec.jalr = 1'b1; w_dec.reg_wr_en = 1'b1;
            end
            7'b1100011: begin
                w_ok = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_dec.imm_fmt = IMM_B; w_dec.alu_op = ALU_SUB; w_dec.branch = 1'b1;
            end
            7'b0000011: begin
                w_ok = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
                w_dec.alu_src_b = 1'b1; w_dec.mem_rd = 1'b1; w_dec.reg_wr_en = 1'b1;
                w_dec.mem_size = {1'b0, w_f3[1:0]}; w_dec.mem_unsigned = w_f3[2];
            end
            7'b0100011: begin
                w_ok = (w_f3 <= 3'b010); w_dec.imm_fmt = IMM_S; w_dec.alu_src_b = 1'b1;
                w_dec.mem_wr = 1'b1; w_dec.mem_size = {1'b0, w_f3[1:0]};
            end
            7'b0010011: begin
                w_dec.alu_src_b = 1'b1; w_dec.reg_wr_en = 1'b1; w_dec.alu_op = w_alu_f3;
                if (w_f3 == 3'b001) begin
                    w_ok = (w_f7 == 7'h00);
                end else if (w_f3 == 3'b101) begin
                    w_ok = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                    if (w_f7 == 7'h20) w_dec.alu_op = ALU_SRA;
                end else begin
                    w_ok = 1'b1;
                end
            end
            7'b0110011: begin
                w_dec.imm_fmt = IMM_R; w_dec.reg_wr_en = 1'b1;
                if (EN_M && (w_f7 == 7'h01)) begin
                    w_ok = 1'b1; w_dec.mdu_en = 1'b1;
                end else begin
                    w_dec.alu_op = w_alu_f3;
                    if (w_f7 == 7'h00) begin
                        w_ok = 1'b1;
                    end else if ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) begin
                        w_ok = 1'b1; w_dec.alu_op = w_alu_f3 + 4'd1;
                    end
                end
            end
            7'b1110011: begin
                if ((w_f3 != 3'b000) && (w_f3 != 3'b100)) begin
                    w_ok = EN_ZICSR; w_dec.csr_en = 1'b1; w_dec.reg_wr_en = 1'b1;
                end else if (bus.in_instr == 32'h0000_0073) begin
                    w_ok = EN_ZICSR; w_dec.ecall = 1'b1;
                end else if (bus.in_instr == 32'h3020_0073) begin
                    w_ok = EN_ZICSR; w_dec.mret = 1'b1;
                end else if (bus.in_instr == 32'h0010_0073) begin
                    w_ok = 1'b1; w_dec.ebreak = 1'b1;
                end
            end
            default: w_ok = 1'b0;
        endcase
        if (!w_ok) begin
            w_dec.illegal   = 1'b1;
            w_dec.reg_wr_en = 1'b0; w_dec.mem_rd = 1'b0; w_dec.mem_wr = 1'b0;
            w_dec.branch    = 1'b0; w_dec.jump   = 1'b0; w_dec.jalr   = 1'b0;
            w_dec.mdu_en    = 1'b0; w_dec.csr_en = 1'b0;
            w_dec.ecall     = 1'b0; w_dec.mret   = 1'b0; w_dec.ebreak = 1'b0;
        end
    end

    assign bus.in_ready = !r_skid_valid && !r_halted;
    assign w_in_xfer    = bus.in_valid && bus.in_ready;
    assign w_out_xfer   = r_out_valid && bus.out_ready;
    assign w_out_free   = !r_out_valid || bus.out_ready;

    // The skid can only be occupied while in_ready is low, so it never competes with a new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out           <= '0;
            r_out.mem_size  <= 3'b010;
            r_skid          <= '0;
            r_skid.mem_size <= 3'b010;
            r_out_valid     <= 1'b0;
            r_skid_valid    <= 1'b0;
            r_halted        <= 1'b0;
            r_cnt           <= '0;
        end else begin
            if (i_flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_xfer) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
            if (w_out_xfer && r_out.illegal && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
            if (i_resume) begin
                r_halted <= 1'b0;
            end else if (HALT_ON_EBREAK && w_in_xfer && !i_flush && w_dec.ebreak) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign o_halted        = r_halted;
    assign o_illegal_count = r_cnt;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_out.pc;
    assign bus.out_instr   = r_out.instr;
    assign bus.rs1         = r_out.rs1;
    assign bus.rs2         = r_out.rs2;
    assign bus.rd          = r_out.rd;
    assign bus.alu_op      = r_out.alu_op;
    assign bus.alu_src_a   = r_out.alu_src_a;
    assign bus.alu_src_b   = r_out.alu_src_b;
    assign bus.imm_fmt     = r_out.imm_fmt;
    assign bus.reg_wr_en   = r_out.reg_wr_en;
    assign bus.mem_rd      = r_out.mem_rd;
    assign bus.mem_wr      = r_out.mem_wr;
    assign bus.mem_unsigned = r_out.mem_unsigned;
    assign bus.mem_size    = r_out.mem_size;
    assign bus.branch      = r_out.branch;
    assign bus.jump        = r_out.jump;
    assign bus.jalr        = r_out.jalr;
    assign bus.branch_op   = r_out.branch_op;
    assign bus.mdu_en      = r_out.mdu_en;
    assign bus.mdu_op      = r_out.mdu_op;
    assign bus.csr_en      = r_out.csr_en;
    assign bus.csr_op      = r_out.csr_op;
    assign bus.csr_imm     = r_out.csr_imm;
    assign bus.ecall       = r_out.ecall;
    assign bus.mret        = r_out.mret;
    assign bus.ebreak      = r_out.ebreak;
    assign bus.illegal     = r_out.illegal;
endmodule

// File: tb/tb_rv32_decode_stage.sv
// Two decode stages (full ISA with 4-bit counter; RV32I-only with 16-bit counter) share one
// stimulus stream and are checked against a queue-based reference model every cycle.
module tb_rv32_decode_stage;
    localparam logic [31:0] I_ADD    = 32'h002081B3;
    localparam logic [31:0] I_MUL    = 32'h022081B3;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
    localparam logic [31:0] I_CSRRW  = 32'h300110F3;
    localparam logic [31:0] I_BAD    = 32'hFFFFFFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic [1:0]  alu_src_a;
        logic        alu_src_b;
        logic [2:0]  imm_fmt;
        logic        reg_wr_en, mem_rd, mem_wr, mem_unsigned;
        logic [2:0]  mem_size;
        logic        branch, jump, jalr;
        logic [2:0]  branch_op;
        logic        mdu_en;
        logic [2:0]  mdu_op;
        logic        csr_en;
        logic [1:0]  csr_op;
        logic        csr_imm;
        logic        ecall, mret, ebreak, illegal;
    } bun_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        flush  = 1'b0;
    logic        resume = 1'b0;
    logic        halt_a, halt_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;
    bun_t        got_a, got_b;

    always #5 clk = ~clk;

    rv32_decode_stage_if ifa ();
    rv32_decode_stage_if ifb ();

    rv32_decode_stage #(.EN_M(1'b1), .EN_ZICSR(1'b1), .HALT_ON_EBREAK(1'b1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_resume(resume),
        .bus(ifa.slave), .o_halted(halt_a), .o_illegal_count(cnt_a));

    rv32_decode_stage #(.EN_M(1'b0), .EN_ZICSR(1'b0), .HALT_ON_EBREAK(1'b1), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_resume(resume),
        .bus(ifb.slave), .o_halted(halt_b), .o_illegal_count(cnt_b));

    assign got_a = {ifa.out_pc, ifa.out_instr, ifa.rs1, ifa.rs2, ifa.rd, ifa.alu_op, ifa.alu_src_a,
                    ifa.alu_src_b, ifa.imm_fmt, ifa.reg_wr_en, ifa.mem_rd, ifa.mem_wr, ifa.mem_unsigned,
                    ifa.mem_size, ifa.branch, ifa.jump, ifa.jalr, ifa.branch_op, ifa.mdu_en, ifa.mdu_op,
                    ifa.csr_en, ifa.csr_op, ifa.csr_imm, ifa.ecall, ifa.mret, ifa.ebreak, ifa.illegal};
    assign got_b = {ifb.out_pc, ifb.out_instr, ifb.rs1, ifb.rs2, ifb.rd, ifb.alu_op, ifb.alu_src_a,
                    ifb.alu_src_b, ifb.imm_fmt, ifb.reg_wr_en, ifb.mem_rd, ifb.mem_wr, ifb.mem_unsigned,
                    ifb.mem_size, ifb.branch, ifb.jump, ifb.jalr, ifb.branch_op, ifb.mdu_en, ifb.mdu_op,
                    ifb.csr_en, ifb.csr_op, ifb.csr_imm, ifb.ecall, ifb.mret, ifb.ebreak, ifb.illegal};

    ent_t        q[$];
    bit          m_halted;
    int          m_cnt_a, m_cnt_b;
    int          n_chk = 0, n_bad = 0, n_seen;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected bundle from the ISA rules: class of instruction -> operand sources and enables.
    function automatic bun_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                     input bit en_m, input bit en_z);
        bun_t b;
        bit ok;
        int alu_tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        b = '0; ok = 0;
        b.pc = pc; b.instr = ins; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
        b.mem_size = 3'b010; b.branch_op = f3; b.mdu_op = f3; b.csr_op = f3[1:0]; b.csr_imm = f3[2];
        if (op == 7'h37) begin
            ok = 1; b.imm_fmt = 3; b.alu_src_a = 2; b.alu_src_b = 1; b.reg_wr_en = 1;
        end else if (op == 7'h17) begin
            ok = 1; b.imm_fmt = 3; b.alu_src_a = 1; b.alu_src_b = 1; b.reg_wr_en = 1;
        end else if (op == 7'h6F) begin
            ok = 1; b.imm_fmt = 4; b.alu_src_a = 1; b.alu_src_b = 1; b.jump = 1; b.reg_wr_en = 1;
        end else if (op == 7'h67) begin
            ok = (f3 == 0); b.alu_src_b = 1; b.jump = 1; b.jalr = 1; b.reg_wr_en = 1;
        end else if (op == 7'h63) begin
            ok = !(f3 inside {3'd2, 3'd3}); b.imm_fmt = 2; b.alu_op = 1; b.branch = 1;
        end else if (op == 7'h03) begin
            ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            b.alu_src_b = 1; b.mem_rd = 1; b.reg_wr_en = 1;
            b.mem_size = {1'b0, f3[1:0]}; b.mem_unsigned = f3[2];
        end else if (op == 7'h23) begin
            ok = (f3 <= 2); b.imm_fmt = 1; b.alu_src_b = 1; b.mem_wr = 1; b.mem_size = {1'b0, f3[1:0]};
        end else if (op == 7'h13) begin
            ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            b.alu_op = 4'(alu_tbl[f3] + ((f3 == 5 && f7 == 7'h20) ? 1 : 0));
            b.alu_src_b = 1; b.reg_wr_en = 1;
        end else if (op == 7'h33) begin
            b.imm_fmt = 5; b.reg_wr_en = 1;
            if (en_m && f7 == 7'h01) begin
                ok = 1; b.mdu_en = 1;
            end else begin
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                b.alu_op = 4'(alu_tbl[f3] + ((f7 == 7'h20) ? 1 : 0));
            end
        end else if (op == 7'h73) begin
            if (f3 != 0 && f3 != 4) begin ok = en_z; b.csr_en = 1; b.reg_wr_en = 1; end
            else if (ins == 32'h0000_0073) begin ok = en_z; b.ecall = 1; end
            else if (ins == 32'h3020_0073) begin ok = en_z; b.mret = 1; end
            else if (ins == I_EBREAK) begin ok = 1; b.ebreak = 1; end
        end
        if (!ok) begin
            b.illegal = 1; b.reg_wr_en = 0; b.mem_rd = 0; b.mem_wr = 0; b.branch = 0; b.jump = 0;
            b.jalr = 0; b.mdu_en = 0; b.csr_en = 0; b.ecall = 0; b.mret = 0; b.ebreak = 0;
        end
        return b;
    endfunction

    // Datapath selections of an illegal bundle carry no meaning and are not compared.
    function automatic bun_t care(input bun_t e);
        bun_t m;
        m = '1;
        if (e.illegal) begin
            m.alu_op = 0; m.alu_src_a = 0; m.alu_src_b = 0; m.imm_fmt = 0;
            m.mem_size = 0; m.mem_unsigned = 0;
        end
        return m;
    endfunction

    task automatic check_state();
        bun_t ea, eb;
        bit   exp_ir;
        exp_ir = (q.size() < 2) && !m_halted;
        chk("in_ready_a", 128'(ifa.in_ready), 128'(exp_ir));
        chk("in_ready_b", 128'(ifb.in_ready), 128'(exp_ir));
        chk("out_valid_a", 128'(ifa.out_valid), 128'(q.size() > 0));
        chk("out_valid_b", 128'(ifb.out_valid), 128'(q.size() > 0));
        chk("halted_a", 128'(halt_a), 128'(m_halted));
        chk("halted_b", 128'(halt_b), 128'(m_halted));
        chk("count_a", 128'(cnt_a), 128'(m_cnt_a));
        chk("count_b", 128'(cnt_b), 128'(m_cnt_b));
        if (q.size() > 0) begin
            ea = ref_dec(q[0].ins, q[0].pc, 1'b1, 1'b1);
            eb = ref_dec(q[0].ins, q[0].pc, 1'b0, 1'b0);
            chk("bundle_a", 128'(got_a & care(ea)), 128'(ea & care(ea)));
            chk("bundle_b", 128'(got_b & care(eb)), 128'(eb & care(eb)));
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit ordy, input bit fl, input bit rs);
        ifa.in_valid = v;      ifb.in_valid = v;
        ifa.in_instr = ins;    ifb.in_instr = ins;
        ifa.in_pc = pc_ctr;    ifb.in_pc = pc_ctr;
        ifa.out_ready = ordy;  ifb.out_ready = ordy;
        flush = fl;            resume = rs;
    endtask

    // Check the current cycle, apply new inputs, advance the model across the next edge.
    task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl, input bit rs);
        bit   ir, oxf, ixf;
        bun_t d;
        check_state();
        pc_ctr = pc_ctr + 32'd4;
        drive(v, ins, ordy, fl, rs);
        ir  = (q.size() < 2) && !m_halted;
        oxf = (q.size() > 0) && ordy;
        ixf = v && ir;
        if (ifa.out_valid && ordy) n_seen++;
        if (oxf) begin
            d = ref_dec(q[0].ins, q[0].pc, 1'b1, 1'b1);
            if (d.illegal && m_cnt_a < 15) m_cnt_a++;
            d = ref_dec(q[0].ins, q[0].pc, 1'b0, 1'b0);
            if (d.illegal && m_cnt_b < 65535) m_cnt_b++;
            void'(q.pop_front());
        end
        if (fl) q.delete();
        else if (ixf) q.push_back('{pc: pc_ctr, ins: ins});
        if (rs) m_halted = 0;
        else if (ixf && !fl && ins == I_EBREAK) m_halted = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel, f7s;
        w   = $urandom;
        sel = int'($urandom_range(0, 13));
        f7s = int'($urandom_range(0, 3));
        if (f7s == 0) w[31:25] = 7'h00;
        else if (f7s == 1) w[31:25] = 7'h20;
        else if (f7s == 2) w[31:25] = 7'h01;
        case (sel)
            0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
            8: w[6:0] = 7'h33;  9: w[6:0] = 7'h73;  10: w = I_EBREAK;   11: w = 32'h0000_0073;
            12: w = 32'h3020_0073;
            default: w = w;
        endcase
        return w;
    endfunction

    task automatic check_reset_values();
        bun_t rb;
        rb = '0;
        rb.mem_size = 3'b010;
        chk("rst_out_valid_a", 128'(ifa.out_valid), 128'(0));
        chk("rst_out_valid_b", 128'(ifb.out_valid), 128'(0));
        chk("rst_bundle_a", 128'(got_a), 128'(rb));
        chk("rst_bundle_b", 128'(got_b), 128'(rb));
        chk("rst_halted_a", 128'(halt_a), 128'(0));
        chk("rst_count_a", 128'(cnt_a), 128'(0));
        chk("rst_count_b", 128'(cnt_b), 128'(0));
    endtask

    task automatic model_reset();
        q.delete();
        m_halted = 0;
        m_cnt_a  = 0;
        m_cnt_b  = 0;
    endtask

    initial begin
        bit v, ordy, fl, rs;
        int k;
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0);
        chk("add_valid", 128'(ifa.out_valid), 128'(1));
        chk("add_rs1", 128'(ifa.rs1), 128'(1));
        chk("add_rs2", 128'(ifa.rs2), 128'(2));
        chk("add_rd", 128'(ifa.rd), 128'(3));
        chk("add_alu_op", 128'(ifa.alu_op), 128'(0));
        chk("add_imm_fmt", 128'(ifa.imm_fmt), 128'(5));
        chk("add_wr_en", 128'(ifa.reg_wr_en), 128'(1));
        chk("add_illegal", 128'(ifa.illegal), 128'(0));

        step(1'b1, I_MUL, 1'b1, 1'b0, 1'b0);
        chk("mul_mdu_en_a", 128'(ifa.mdu_en), 128'(1));
        chk("mul_mdu_op_a", 128'(ifa.mdu_op), 128'(0));
        chk("mul_illegal_b", 128'(ifb.illegal), 128'(1));
        chk("mul_wr_en_b", 128'(ifb.reg_wr_en), 128'(0));
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("mul_count_b", 128'(cnt_b), 128'(1));
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // four ADDIs with the output held for three cycles
        k = 0;
        n_seen = 0;
        for (int c = 0; c < 10; c++) begin
            bit acc;
            acc = (k < 4) && (q.size() < 2) && !m_halted;
            if (c == 3) chk("bp_in_ready", 128'(ifa.in_ready), 128'(0));
            step(k < 4, 32'h0000_0093 + 32'(k) * 32'h0010_0000, c >= 3, 1'b0, 1'b0);
            if (acc) k++;
        end
        chk("bp_delivered", 128'(n_seen), 128'(4));

        step(1'b1, I_EBREAK, 1'b1, 1'b0, 1'b0);
        chk("ebreak_halted", 128'(halt_a), 128'(1));
        chk("ebreak_in_ready", 128'(ifa.in_ready), 128'(0));
        chk("ebreak_out", 128'(ifa.ebreak), 128'(1));
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("resume_in_ready", 128'(ifa.in_ready), 128'(1));

        step(1'b1, I_CSRRW, 1'b0, 1'b0, 1'b0);
        chk("csr_en", 128'(ifa.csr_en), 128'(1));
        chk("csr_op", 128'(ifa.csr_op), 128'(1));
        chk("csr_imm", 128'(ifa.csr_imm), 128'(0));
        step(1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
        chk("held_in_ready", 128'(ifa.in_ready), 128'(0));
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("flush_out_valid", 128'(ifa.out_valid), 128'(0));
        chk("flush_in_ready", 128'(ifa.in_ready), 128'(1));

        for (int i = 0; i < 19; i++) step(1'b1, I_BAD, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("sat_count_a", 128'(cnt_a), 128'(4'hF));
        chk("run_count_b", 128'(cnt_b), 128'(20));

        for (int i = 0; i < 2500; i++) begin
            fl   = ($urandom_range(0, 99) < 4);
            rs   = ($urandom_range(0, 7) == 0);
            v    = !fl && ($urandom_range(0, 3) != 0);
            ordy = !fl && ($urandom_range(0, 2) != 0);
            step(v, rand_instr(), ordy, fl, rs);
        end

        step(1'b1, I_BAD, 1'b0, 1'b0, 1'b1);
        step(1'b1, I_ADD, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            rs   = ($urandom_range(0, 7) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 1) == 1, rand_instr(), ordy, 1'b0, rs);
        end
        check_state();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
